clk_div_multi: RTL
==================

Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider, next generation of the fixed even/odd divider in the clock block.
- N independent channels, each with a runtime-loadable divisor. Odd divisors can optionally produce 50% duty.
- Each channel provides:
  - a glitch-free stop/start;
  - a one-cycle tick strobe, usable as a clock enable by downstream SDRAM/controller logic.
- Sits beside the PLL-less clock path and feeds sub-rate enables and divided clocks.

Parameters:
- CH_NUM, 2, number of divider channels.
- DIV_W, 8, divisor width in bits (divisor range 0..2^DIV_W-1).
- DEF_DIV, 4, divisor loaded into every channel at reset.
- ODD_50, 1, 1 = odd divisors give 50% duty (uses falling edge of i_clk); 0 = odd high phase is (D+1)/2 cycles.

Ports:
- i_clk, in, 1, single clock. All flops on its rising edge, except the ODD_50 falling-edge flop.
- i_rst, in, 1, synchronous, active-high reset.
- i_en, in, CH_NUM, per-channel run enable.
- i_load, in, CH_NUM, per-channel divisor load strobe (one-cycle pulse).
- i_div, in, CH_NUM*DIV_W, divisor values. Channel k occupies bits [k*DIV_W +: DIV_W].
- o_clk, out, CH_NUM, divided clocks.
- o_tick, out, CH_NUM, one-cycle strobe at the start of each output period.
- o_busy, out, CH_NUM, a loaded divisor is pending (not yet applied).
- o_ack, out, CH_NUM, one-cycle pulse in the cycle a pending divisor takes effect.

Behaviour:
- Reset (i_rst high at a rising edge), all channels:
  - cnt=0, active divisor D=DEF_DIV, pending cleared, run=0;
  - posedge phase flop p=0, negedge flop n=0;
  - o_clk=0, o_tick=0, o_busy=0, o_ack=0.
- Reset mid-operation aborts the period immediately. Nothing from the previous state survives.
- Effective divisor: D=0 means the channel is stopped (o_clk low, no ticks, cnt held 0). D=1 is treated as 2.
- Per channel, run state: STOP or RUN.
  - STOP -> RUN: i_en=1 and D!=0. The first RUN cycle has cnt=0.
  - RUN -> STOP: only at the period boundary (cnt==D-1) when i_en=0 or D==0. This guarantees no runt pulse.
- Counter in RUN: cnt increments 0..D-1 and wraps to 0.
- Phase flop: p=1 for cnt in [0, ceil(D/2)-1], else 0. p is registered, so o_clk lags the cnt value by one cycle.
  - n samples p on the falling edge of i_clk.
  - ODD_50=1 and D odd: o_clk = p & n, giving high time D/2 cycles.
  - Otherwise: o_clk = p.
- o_tick = 1 in exactly the cycle in which p rises (registered, aligned with the o_clk rising edge when ODD_50 path is unused). Period is D cycles.
- Load handshake:
  - i_load[k] captures i_div slice k into pending and sets o_busy[k] the next cycle.
  - Pending applies at the next period boundary (cnt==D-1 in RUN), or on the next cycle if the channel is in STOP.
  - In the applying cycle: D updates, o_busy clears, o_ack pulses for 1 cycle. The new period starts at cnt=0 with the new D.
  - Load while busy: pending is overwritten. Only one o_ack is issued, for the last value.
  - Load in the same cycle as the apply condition: the old pending applies and acks; the new value becomes pending (busy stays 1).
- Channels are fully independent. No cross-channel phase alignment.

Decomposition:
- Package clk_pkg:
  - DIV_W default;
  - run state enum (ST_STOP, ST_RUN);
  - helper function half_hi(D) = ceil(D/2);
  - constant MIN_DIV = 2.
- Sub-module clk_div_chan: one channel (counter, state, phase flops, pending register, tick/ack). Generated CH_NUM times in clk_div_multi, which only slices the buses.

Test Plan:
- Reset release, DEF_DIV=4, i_en=1 on ch0 -> o_clk 2 cycles high / 2 low, o_tick every 4 cycles, o_busy=0 and o_ack=0 throughout.
- Load D=5 with ODD_50=1 (20 ns clock) -> o_clk high 50 ns, low 50 ns, period 100 ns; o_ack pulses once at the old period boundary; first period after the ack has cnt restarting at 0.
- Load D=7 then D=6 two cycles apart during a D=4 period -> single o_ack, applied D=6 (3 high / 3 low), o_busy high until the ack cycle.
- i_en dropped mid high-phase at D=8 -> o_clk completes the full 8-cycle period, then stays low, no further o_tick; re-raise i_en -> first tick the next cycle.
- Load D=0 -> channel stops at the boundary with o_clk low. Load D=1 -> runs as D=2 (toggle every cycle).
- i_rst asserted mid-period on both channels with a pending load -> next cycle all outputs 0, D back to 4, pending discarded (no o_ack).

Source files
------------

// File: rtl/clk_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Run-state enum, minimum usable divisor and the high-phase helper.
package clk_pkg;

    localparam int DIV_W_DEF = 8;
    localparam int MIN_DIV   = 2;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } run_e;

    // Number of cycles the phase flop stays high: ceil(d/2)
    function automatic logic [31:0] half_hi(input logic [31:0] d);
        return (d + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: run FSM, period counter, phase flops, pending divisor.
// Ports: i_clk, i_rst (sync, high), i_en, i_load, i_div -> o_clk, o_tick, o_busy, o_ack.
module clk_div_chan
    import clk_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = 4,
    parameter int ODD_50  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_busy,
    output logic             o_ack
);

    run_e             r_state;
    run_e             w_state_nx;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nx;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_pend;
    logic             r_busy;
    logic             r_p;
    logic             r_n;
    logic             r_tick;
    logic             r_ack;

    logic [DIV_W-1:0] w_deff;
    logic [DIV_W-1:0] w_half;
    logic [DIV_W-1:0] w_div_nx;
    logic             w_run;
    logic             w_last;
    logic             w_apply;
    logic             w_go;
    logic             w_odd;

    // A divisor of 1 cannot form a high and a low phase, so it runs as 2
    assign w_deff   = (r_div == DIV_W'(1)) ? DIV_W'(MIN_DIV) : r_div;
    assign w_half   = DIV_W'(half_hi(32'(w_deff)));
    assign w_run    = (r_state == ST_RUN);
    assign w_last   = w_run && (r_cnt == w_deff - 1'b1);
    // Pending divisor only lands on a period boundary or while stopped
    assign w_apply  = r_busy && (!w_run || w_last);
    assign w_div_nx = w_apply ? r_pend : r_div;
    assign w_go     = i_en && (w_div_nx != '0);
    assign w_odd    = (ODD_50 != 0) && w_deff[0];

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        unique case (r_state)
            ST_STOP: begin
                w_cnt_nx = '0;
                if (w_go) w_state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (w_last) begin
                    w_cnt_nx = '0;
                    if (!w_go) w_state_nx = ST_STOP;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_STOP;
            r_cnt   <= '0;
            r_div   <= DIV_W'(DEF_DIV);
            r_pend  <= '0;
            r_busy  <= 1'b0;
            r_p     <= 1'b0;
            r_tick  <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_div   <= w_div_nx;
            r_p     <= w_run && (r_cnt < w_half);
            // p can only rise out of cnt==0, so this marks the rising edge
            r_tick  <= w_run && (r_cnt == '0);
            r_ack   <= w_apply;
            if (i_load) begin
                r_pend <= i_div;
                r_busy <= 1'b1;
            end else if (w_apply) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Half-cycle delayed copy of p trims the odd high phase to D/2
    always_ff @(negedge i_clk) begin
        if (i_rst) r_n <= 1'b0;
        else       r_n <= r_p;
    end

    assign o_clk  = w_odd ? (r_p & r_n) : r_p;
    assign o_tick = r_tick;
    assign o_busy = r_busy;
    assign o_ack  = r_ack;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider; slices buses into CH_NUM channels.
// Ports: i_clk, i_rst, i_en/i_load [CH], i_div [CH*DIV_W] -> o_clk/o_tick/o_busy/o_ack [CH].
module clk_div_multi
    import clk_pkg::*;
#(
    parameter int CH_NUM  = 2,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = 4,
    parameter int ODD_50  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [CH_NUM-1:0]       i_en,
    input  logic [CH_NUM-1:0]       i_load,
    input  logic [CH_NUM*DIV_W-1:0] i_div,
    output logic [CH_NUM-1:0]       o_clk,
    output logic [CH_NUM-1:0]       o_tick,
    output logic [CH_NUM-1:0]       o_busy,
    output logic [CH_NUM-1:0]       o_ack
);

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        clk_div_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV),
            .ODD_50  (ODD_50)
        ) u_chan (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_en   (i_en[g]),
            .i_load (i_load[g]),
            .i_div  (i_div[g*DIV_W +: DIV_W]),
            .o_clk  (o_clk[g]),
            .o_tick (o_tick[g]),
            .o_busy (o_busy[g]),
            .o_ack  (o_ack[g])
        );
    end

endmodule
